// File: rtl/lock_sequencer.sv
// -----------------------------------------------------------------------------
// lock_sequencer
//
// Sequencing controller for the digit-comparator datapath of the security
// lock. One keypad digit is accepted per digit_valid strobe; the current digit
// index (pos) and the alarm flag are driven to the primary and secondary
// comparators, whose combinational per-digit results come back on match_pri /
// match_sec in the same cycle. Mismatches are accumulated into a sticky flag.
// At the end of an attempt the block unlocks, counts a failure, escalates to
// alarm mode (secondary password), or enters a timed lockout.
//
// Optional feature macro: LOCK_LOCKOUT_EN
//   defined   - a failed alarm-mode attempt enters LOCKOUT for LOCKOUT_CYCLES
//   undefined - no LOCKOUT state; a failed alarm-mode attempt stays in ENTRY
//               and locked_out is tied low
//
// Parameters:
//   PRI_LEN        digits in the primary password (1..7)
//   SEC_LEN        digits in the secondary/alarm password (1..7)
//   MAX_FAIL       failed primary attempts that raise alarm (1..7)
//   UNLOCK_CYCLES  cycles unlock stays high (>=1)
//   LOCKOUT_CYCLES cycles keypad input is ignored after a failed alarm attempt
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   digit_valid  in   one-cycle keypad digit strobe
//   clear        in   abort the current entry (wins over digit_valid)
//   match_pri    in   primary comparator result for the digit at pos
//   match_sec    in   secondary comparator result for the digit at pos
//   pos          out  [2:0] 0-based index of the digit being entered
//   alarm        out  alarm mode; selects the secondary comparator
//   unlock       out  lock release
//   fail_pulse   out  one-cycle pulse per completed wrong attempt
//   fail_cnt     out  [2:0] failed primary attempts since last success
//   locked_out   out  high while keypad input is ignored
// -----------------------------------------------------------------------------
module lock_sequencer #(
  parameter int PRI_LEN        = 4,
  parameter int SEC_LEN        = 5,
  parameter int MAX_FAIL       = 3,
  parameter int UNLOCK_CYCLES  = 16,
  parameter int LOCKOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       digit_valid,
  input  logic       clear,
  input  logic       match_pri,
  input  logic       match_sec,
  output logic [2:0] pos,
  output logic       alarm,
  output logic       unlock,
  output logic       fail_pulse,
  output logic [2:0] fail_cnt,
  output logic       locked_out
);

  // One shared dwell counter serves both timed states, so it is sized for the
  // longer of the two.
  localparam int DWELL_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES
                                                              : LOCKOUT_CYCLES;
  localparam int DWELL_W   = $clog2(DWELL_MAX + 1);

  // The counter is loaded with N-1 and the state exits when it reads zero,
  // which gives exactly N cycles of the registered output.
  localparam logic [DWELL_W-1:0] UNLOCK_LOAD  = DWELL_W'(UNLOCK_CYCLES - 1);
`ifdef LOCK_LOCKOUT_EN
  localparam logic [DWELL_W-1:0] LOCKOUT_LOAD = DWELL_W'(LOCKOUT_CYCLES - 1);
`endif

  localparam logic [2:0] PRI_LAST = 3'(PRI_LEN - 1);
  localparam logic [2:0] SEC_LAST = 3'(SEC_LEN - 1);
  localparam logic [2:0] FAIL_MAX = 3'(MAX_FAIL);

  typedef enum logic [1:0] {
    ENTRY    = 2'd0,
    UNLOCKED = 2'd1
`ifdef LOCK_LOCKOUT_EN
    ,
    LOCKOUT  = 2'd2
`endif
  } state_t;

  state_t               state, state_nxt;
  logic [DWELL_W-1:0]   dwell, dwell_nxt;
  logic                 bad, bad_nxt;
  logic [2:0]           pos_nxt;
  logic [2:0]           fail_cnt_nxt;
  logic                 alarm_nxt;
  logic                 fail_pulse_nxt;

  logic [2:0]           len_last;
  logic                 match_sel;
  logic                 bad_acc;
  logic [2:0]           fail_inc;

  // Comparator selection follows the alarm flag; alarm only changes at an
  // attempt boundary (pos = 0), so an attempt never mixes the two passwords.
  assign len_last  = alarm ? SEC_LAST : PRI_LAST;
  assign match_sel = alarm ? match_sec : match_pri;
  assign bad_acc   = bad | ~match_sel;
  // fail_cnt only increments while alarm is low, i.e. below MAX_FAIL <= 7,
  // so this never wraps.
  assign fail_inc  = fail_cnt + 3'd1;

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt      = state;
    dwell_nxt      = dwell;
    bad_nxt        = bad;
    pos_nxt        = pos;
    fail_cnt_nxt   = fail_cnt;
    alarm_nxt      = alarm;
    fail_pulse_nxt = 1'b0;

    case (state)
      ENTRY: begin
        if (clear) begin
          // Abort only: not counted as a failure, simultaneous digit dropped.
          pos_nxt = 3'd0;
          bad_nxt = 1'b0;
        end else if (digit_valid) begin
          if (pos < len_last) begin
            pos_nxt = pos + 3'd1;
            bad_nxt = bad_acc;
          end else begin
            pos_nxt = 3'd0;
            bad_nxt = 1'b0;
            if (!bad_acc) begin
              state_nxt    = UNLOCKED;
              dwell_nxt    = UNLOCK_LOAD;
              fail_cnt_nxt = 3'd0;
              alarm_nxt    = 1'b0;
            end else if (!alarm) begin
              fail_pulse_nxt = 1'b1;
              fail_cnt_nxt   = fail_inc;
              if (fail_inc == FAIL_MAX) begin
                alarm_nxt = 1'b1;
              end
            end else begin
              // Alarm-mode failure: fail_cnt is already saturated at MAX_FAIL.
              fail_pulse_nxt = 1'b1;
`ifdef LOCK_LOCKOUT_EN
              state_nxt      = LOCKOUT;
              dwell_nxt      = LOCKOUT_LOAD;
`endif
            end
          end
        end
      end

      UNLOCKED: begin
        if (dwell == '0) begin
          state_nxt = ENTRY;
        end else begin
          dwell_nxt = dwell - 1'b1;
        end
      end

`ifdef LOCK_LOCKOUT_EN
      LOCKOUT: begin
        // alarm is deliberately left set on return to ENTRY.
        if (dwell == '0) begin
          state_nxt = ENTRY;
        end else begin
          dwell_nxt = dwell - 1'b1;
        end
      end
`endif

      default: begin
        state_nxt = ENTRY;
        dwell_nxt = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ENTRY;
      dwell      <= '0;
      bad        <= 1'b0;
      pos        <= 3'd0;
      fail_cnt   <= 3'd0;
      alarm      <= 1'b0;
      fail_pulse <= 1'b0;
      unlock     <= 1'b0;
    end else begin
      state      <= state_nxt;
      dwell      <= dwell_nxt;
      bad        <= bad_nxt;
      pos        <= pos_nxt;
      fail_cnt   <= fail_cnt_nxt;
      alarm      <= alarm_nxt;
      fail_pulse <= fail_pulse_nxt;
      // Decoded from the next state so the output is a flop, not state decode.
      unlock     <= (state_nxt == UNLOCKED);
    end
  end

`ifdef LOCK_LOCKOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked_out <= 1'b0;
    end else begin
      locked_out <= (state_nxt == LOCKOUT);
    end
  end
`else
  assign locked_out = 1'b0;
`endif

endmodule

// File: tb/tb_lock_sequencer.sv
module tb_lock_sequencer;

  localparam int PRI_LEN        = 4;
  localparam int SEC_LEN        = 5;
  localparam int MAX_FAIL       = 3;
  localparam int UNLOCK_CYCLES  = 16;
  localparam int LOCKOUT_CYCLES = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       digit_valid = 1'b0;
  logic       clear = 1'b0;
  logic       match_pri = 1'b0;
  logic       match_sec = 1'b0;
  logic [2:0] pos;
  logic       alarm;
  logic       unlock;
  logic       fail_pulse;
  logic [2:0] fail_cnt;
  logic       locked_out;

  int total = 0;
  int bad = 0;

  // Reference model: the attempt is a queue of selected match bits; the
  // timed states are "cycles of output still owed".
  bit mq[$];
  int m_fails;
  bit m_alarm;
  int rem_unlock;
  int rem_lock;
  bit m_pulse;

  always #5 clk = ~clk;

  lock_sequencer #(
    .PRI_LEN(PRI_LEN),
    .SEC_LEN(SEC_LEN),
    .MAX_FAIL(MAX_FAIL),
    .UNLOCK_CYCLES(UNLOCK_CYCLES),
    .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .digit_valid(digit_valid),
    .clear(clear),
    .match_pri(match_pri),
    .match_sec(match_sec),
    .pos(pos),
    .alarm(alarm),
    .unlock(unlock),
    .fail_pulse(fail_pulse),
    .fail_cnt(fail_cnt),
    .locked_out(locked_out)
  );

  task automatic m_reset();
    mq.delete();
    m_fails    = 0;
    m_alarm    = 0;
    rem_unlock = 0;
    rem_lock   = 0;
    m_pulse    = 0;
  endtask

  task automatic model_step(input bit dv, input bit clr, input bit mp, input bit ms);
    bit ok;
    int len;
    m_pulse = 0;
    if (rem_unlock > 0) begin
      rem_unlock--;
    end else if (rem_lock > 0) begin
      rem_lock--;
    end else if (clr) begin
      mq.delete();
    end else if (dv) begin
      len = m_alarm ? SEC_LEN : PRI_LEN;
      mq.push_back(m_alarm ? ms : mp);
      if (mq.size() == len) begin
        ok = 1;
        foreach (mq[i]) if (!mq[i]) ok = 0;
        mq.delete();
        if (ok) begin
          rem_unlock = UNLOCK_CYCLES;
          m_fails    = 0;
          m_alarm    = 0;
        end else begin
          m_pulse = 1;
          if (!m_alarm) begin
            m_fails++;
            if (m_fails == MAX_FAIL) m_alarm = 1;
          end else begin
`ifdef LOCK_LOCKOUT_EN
            rem_lock = LOCKOUT_CYCLES;
`endif
          end
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pos"},        8'(pos),        8'(mq.size()));
    chk({tag, ".alarm"},      8'(alarm),      8'(m_alarm));
    chk({tag, ".unlock"},     8'(unlock),     8'(rem_unlock > 0));
    chk({tag, ".fail_pulse"}, 8'(fail_pulse), 8'(m_pulse));
    chk({tag, ".fail_cnt"},   8'(fail_cnt),   8'(m_fails));
    chk({tag, ".locked_out"}, 8'(locked_out), 8'(rem_lock > 0));
  endtask

  task automatic tick(input bit dv, input bit clr, input bit mp, input bit ms);
    digit_valid = dv;
    clear       = clr;
    match_pri   = mp;
    match_sec   = ms;
    @(posedge clk);
    model_step(dv, clr, mp, ms);
    #1 check_all("cyc");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'($urandom), 1'($urandom));
  endtask

  // One attempt of n digits; digit badpos mismatches on the selected
  // comparator (-1 = all correct). The unselected comparator gets the
  // opposite value so a wrong selection is visible.
  task automatic attempt(input int n, input int badpos, input bit sec);
    bit v;
    for (int i = 0; i < n; i++) begin
      v = (i != badpos);
      if (sec) tick(1'b1, 1'b0, ~v, v);
      else     tick(1'b1, 1'b0, v, ~v);
    end
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    digit_valid = 1'b0;
    clear = 1'b0;
    #1 m_reset();
    check_all("async_rst");
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  int cnt;

  initial begin
    m_reset();
    repeat (2) @(posedge clk);
    #1 check_all("reset");
    #2 rst_n = 1'b1;

    // Correct primary entry, unlock length, strobe on first ENTRY cycle after.
    attempt(PRI_LEN, -1, 1'b0);
    chk("pri_unlock", 8'(unlock), 8'd1);
    cnt = 0;
    for (int i = 0; i < 100 && unlock === 1'b1; i++) begin
      cnt++;
      tick(1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk("unlock_len", 8'(cnt), 8'(UNLOCK_CYCLES));
    tick(1'b1, 1'b0, 1'b1, 1'b0);
    chk("reentry_accept", 8'(pos), 8'd1);
    tick(1'b0, 1'b1, 1'b0, 1'b0);

    // Three primary failures escalate to alarm; secondary password unlocks.
    for (int k = 0; k < MAX_FAIL; k++) begin
      attempt(PRI_LEN, 2, 1'b0);
      chk("fail_pulse_k", 8'(fail_pulse), 8'd1);
      idle(2);
    end
    chk("alarm_set", 8'(alarm), 8'd1);
    chk("fail_cnt_max", 8'(fail_cnt), 8'(MAX_FAIL));
    attempt(SEC_LEN, -1, 1'b1);
    chk("sec_unlock", 8'(unlock), 8'd1);
    chk("sec_alarm_clr", 8'(alarm), 8'd0);
    idle(UNLOCK_CYCLES + 2);

    // Alarm-mode failure: lockout (or not, when the feature is absent).
    for (int k = 0; k < MAX_FAIL; k++) attempt(PRI_LEN, k, 1'b0);
    attempt(SEC_LEN, 4, 1'b1);
`ifdef LOCK_LOCKOUT_EN
    cnt = 0;
    for (int i = 0; i < 200 && locked_out === 1'b1; i++) begin
      cnt++;
      tick(1'($urandom), 1'b0, 1'b1, 1'b1);
      chk("lockout_pos", 8'(pos), 8'd0);
    end
    chk("lockout_len", 8'(cnt), 8'(LOCKOUT_CYCLES));
    chk("lockout_alarm", 8'(alarm), 8'd1);
`else
    chk("no_lockout", 8'(locked_out), 8'd0);
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    chk("next_digit", 8'(pos), 8'd1);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
`endif
    attempt(SEC_LEN, -1, 1'b1);
    idle(UNLOCK_CYCLES + 1);

    // Clear with a simultaneous strobe after two digits.
    attempt(2, -1, 1'b0);
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    chk("clear_pos", 8'(pos), 8'd0);
    chk("clear_nopulse", 8'(fail_pulse), 8'd0);
    attempt(PRI_LEN, -1, 1'b0);
    chk("clear_unlock", 8'(unlock), 8'd1);

    // Asynchronous reset mid-unlock, then mid-lockout (or mid-attempt).
    idle(3);
    async_reset();
    attempt(PRI_LEN, -1, 1'b0);
    chk("rst_unlock", 8'(unlock), 8'd1);
    idle(UNLOCK_CYCLES);
    for (int k = 0; k < MAX_FAIL; k++) attempt(PRI_LEN, 0, 1'b0);
    attempt(SEC_LEN, 1, 1'b1);
    idle(5);
    async_reset();
    attempt(PRI_LEN, -1, 1'b0);
    chk("rst2_unlock", 8'(unlock), 8'd1);
    idle(UNLOCK_CYCLES);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      tick(1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lock_sequencer.md
# lock_sequencer

Sequencing controller for the digit-comparator datapath of the security lock. It accepts one keypad digit per strobe and drives the digit position and alarm mode into the primary and secondary comparators. It accumulates their per-digit match results, counts failed attempts, and escalates to the secondary (alarm) password after repeated failures. It owns the `unlock`, `alarm` and lockout state for the whole lock.

## Interface
- `PRI_LEN`, 4: digits in the primary password (1..7).
- `SEC_LEN`, 5: digits in the secondary/alarm password (1..7).
- `MAX_FAIL`, 3: failed primary attempts that raise `alarm` (1..7).
- `UNLOCK_CYCLES`, 16: cycles `unlock` stays high (≥1).
- `LOCKOUT_CYCLES`, 64: cycles keypad input is ignored after a failed alarm-mode attempt (≥1).

Ports (one clock; reset is asynchronous and active-low):
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous active-low reset.
- `digit_valid` input 1: one-cycle strobe, the keypad digit is present this cycle.
- `clear` input 1: abort the current entry.
- `match_pri` input 1: primary comparator result for the current digit at `pos`.
- `match_sec` input 1: secondary comparator result for the current digit at `pos`.
- `pos` output 3: index of the digit being entered, 0-based; fed to both comparators.
- `alarm` output 1: alarm mode; selects the secondary comparator and drives the alarm indicator.
- `unlock` output 1: lock release.
- `fail_pulse` output 1: one-cycle pulse on every completed wrong attempt.
- `fail_cnt` output 3: failed primary attempts since the last success.
- `locked_out` output 1: high while input is ignored.

## Operation
- States: ENTRY, UNLOCKED, LOCKOUT. Reset state is ENTRY.
- `alarm` is a separate flag; it selects LEN = `SEC_LEN` and match = `match_sec`. Otherwise LEN = `PRI_LEN` and match = `match_pri`.
- ENTRY, on each `digit_valid`:
  - sets sticky `bad` if the selected match is 0;
  - if `pos` < LEN−1, increments `pos`;
  - else ends the attempt: `pos` returns to 0 and `bad` is cleared.
- Attempt end, `bad`=0 and the last match=1:
  - go to UNLOCKED;
  - clear `fail_cnt` and `alarm`.
- Attempt end, failure with `alarm`=0:
  - pulse `fail_pulse` and increment `fail_cnt`;
  - if the new value equals `MAX_FAIL`, set `alarm`.
  - State stays ENTRY.
- Attempt end, failure with `alarm`=1:
  - pulse `fail_pulse`;
  - go to LOCKOUT (see Configuration).
  - `fail_cnt` saturates and stays at `MAX_FAIL`.
- `clear` in ENTRY resets `pos` and `bad` only. It is not a failure. It has priority over a simultaneous `digit_valid`, which is dropped.
- UNLOCKED:
  - `unlock`=1 for `UNLOCK_CYCLES` cycles, then returns to ENTRY;
  - `digit_valid` and `clear` are ignored.
- LOCKOUT:
  - `locked_out`=1 for `LOCKOUT_CYCLES` cycles, then returns to ENTRY with `alarm` still 1;
  - `digit_valid` and `clear` are ignored.
- Counters: the dwell counter is sized to max(`UNLOCK_CYCLES`, `LOCKOUT_CYCLES`) and reloaded on state entry. `pos` and `fail_cnt` are 3-bit unsigned and never wrap.

## Timing
- Reset values: `pos`=0, `alarm`=0, `unlock`=0, `fail_pulse`=0, `fail_cnt`=0, `locked_out`=0, state ENTRY. All counters are 0.
- Reset is asynchronous: asserting `rst_n` mid-attempt, mid-unlock or mid-lockout returns everything to the reset values immediately.
- `match_*` must be valid in the same cycle as `digit_valid`, evaluated against the current `pos`. The comparators are combinational.
- All outputs are registered.
- `pos` advances 1 cycle after the accepting edge.
- `unlock`, `fail_pulse`, updated `fail_cnt`, `alarm` and `locked_out` assert in the cycle after the final digit's edge.
- `unlock` stays high for exactly `UNLOCK_CYCLES` cycles. `locked_out` stays high for exactly `LOCKOUT_CYCLES` cycles.
- A `digit_valid` in the cycle in which ENTRY is re-entered is accepted.

## Configuration
- `LOCK_LOCKOUT_EN`:
  - Defined: a failed alarm-mode attempt enters LOCKOUT as described.
  - Undefined: the LOCKOUT state is not built and a failed alarm-mode attempt stays in ENTRY. `fail_pulse` is still produced, and `locked_out` is tied to 0.

## Test plan
- Reset, then 4 digits all with `match_pri`=1 → `unlock`=1 for 16 cycles, `fail_cnt`=0, `pos` sequence 0,1,2,3,0.
- 3 primary attempts each with digit 2 mismatching → 3 `fail_pulse`, `fail_cnt`=1,2,3, `alarm`=1 after the third; then 5 digits with `match_sec`=1 → `unlock`=1, `alarm`=0, `fail_cnt`=0.
- With `alarm`=1, a wrong 5-digit attempt → `locked_out`=1 for 64 cycles and strobes during it are ignored (`pos` stays 0). Without `LOCK_LOCKOUT_EN`: no lockout, and the next digit is accepted.
- `clear` after 2 digits, with `digit_valid` in the same cycle → `pos`=0, no `fail_pulse`; a following correct 4-digit entry unlocks.
- `rst_n` low for 1 cycle mid-lockout or mid-unlock → all outputs return to their reset values asynchronously; a correct primary entry then unlocks.
- Digit strobe in the first ENTRY cycle after UNLOCKED ends → accepted, `pos`=1.
